// File: rtl/ifetch_unit.sv
// Instruction fetch: issues in-order word fetches, pairs responses with their PCs and buffers them for decode.
// Latency: request to fd_valid is 2 cycles minimum; a full buffer or an unready decode stalls issue, and a redirect flushes.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] ifq_wr_q, ifq_wr_d, ifq_rd_q, ifq_rd_d;

  logic [31:0] buf_instr_q [DEPTH];
  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] ifq_pc_q    [DEPTH];

  logic          issue, rsp, wr, pop;
  logic [OW-1:0] occ;

  // Occupancy counts in-flight fetches plus buffered entries, so every response always has a slot.
  assign occ      = {1'b0, out_cnt_q} + {1'b0, cnt_q};
  assign issue    = reset & ~redirect & (occ < DEPTH_W);
  assign rsp      = imem_rvalid & (out_cnt_q != '0);
  assign wr       = rsp & (drop_cnt_q == '0) & ~redirect;
  assign fd_valid = (cnt_q != '0);
  assign pop      = fd_valid & fd_ready & ~redirect;

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign fd_instr  = fd_valid ? buf_instr_q[head_q] : '0;
  assign fd_pc     = fd_valid ? buf_pc_q[head_q]    : '0;

  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    ifq_wr_d   = ifq_wr_q;
    ifq_rd_d   = ifq_rd_q;

    if (issue) begin
      pc_d     = pc_q + 32'd4;
      ifq_wr_d = ifq_wr_q + PW'(1);
    end
    // The PC queue pops on every accepted response, dropped or not, so it stays aligned across redirects.
    if (rsp) ifq_rd_d = ifq_rd_q + PW'(1);
    out_cnt_d = out_cnt_q + CW'(issue) - CW'(rsp);

    if (redirect) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      drop_cnt_d = out_cnt_q - CW'(rsp);
      cnt_d      = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (wr)  tail_d = tail_q + PW'(1);
      if (pop) head_d = head_q + PW'(1);
      cnt_d = cnt_q + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      ifq_wr_q   <= '0;
      ifq_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ifq_wr_q   <= ifq_wr_d;
      ifq_rd_q   <= ifq_rd_d;
    end
  end

  // Storage needs no reset: entries are only read once the count or in-flight counter says they are valid.
  always_ff @(posedge clk) begin
    if (wr) begin
      buf_instr_q[tail_q] <= imem_rdata;
      buf_pc_q[tail_q]    <= ifq_pc_q[ifq_rd_q];
    end
    if (issue) ifq_pc_q[ifq_wr_q] <= pc_q;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: memory model with random latency, program-order scoreboard of expected fetch/decode PCs.
module tb_ifetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_instr(fd_instr), .fd_pc(fd_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] addr; int due; } req_t;

  int checks = 0, errors = 0;
  int cyc = 0, pops = 0, out_model = 0, last_due = 0;
  int lat_min = 1, lat_max = 1;
  req_t        pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_next, exp_fetch;
  int          m_lat, m_due;
  logic [31:0] m_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // The architectural stream restarts at the target: everything older is never delivered.
  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next  = pc & 32'hFFFF_FFFC;
    exp_fetch = pc & 32'hFFFF_FFFC;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    model_restart(pc);
  endtask

  task automatic do_reset;
    reset    = 1'b0;
    redirect = 1'b0;
    model_restart(RST_PC);
    pend.delete();
    @(negedge clk);
    check("rst fd_valid", 32'(fd_valid), 32'd0);
    check("rst imem_req", 32'(imem_req), 32'd0);
    tick;
    tick;
    reset = 1'b1;
  endtask

  // Memory: in-order responses, each no earlier than its due cycle; also tops up the expected stream.
  always @(posedge clk) begin
    cyc++;
    #1;
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
    if (!reset) begin
      pend.delete();
      imem_rvalid = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      out_model  = 0;
      last_due   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold fd_valid", 32'(fd_valid), 32'd1);
        check("hold fd_pc", fd_pc, prev_pc);
        check("hold fd_instr", fd_instr, prev_instr);
      end
      if (imem_rvalid) begin
        checks++;
        if (out_model == 0) begin
          errors++;
          $display("FAIL protocol: rvalid with no fetch outstanding (cycle %0d)", cyc);
        end else out_model--;
      end
      if (redirect) check("no issue on redirect", 32'(imem_req), 32'd0);
      if (imem_req) begin
        check("imem_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        m_lat = $urandom_range(lat_max, lat_min);
        m_due = cyc + m_lat;
        if (m_due <= last_due) m_due = last_due + 1;
        last_due = m_due;
        pend.push_back('{addr: imem_addr, due: m_due});
        out_model++;
      end
      if (fd_valid && fd_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fd_pc: got %h with no expected entry (cycle %0d)", fd_pc, cyc);
        end else begin
          m_e = exp_q.pop_front();
          check("fd_pc", fd_pc, m_e);
          check("fd_instr", fd_instr, mem_word(m_e));
          pops++;
        end
      end
      prev_stall = fd_valid && !fd_ready && !redirect;
      prev_pc    = fd_pc;
      prev_instr = fd_instr;
    end
  end

  initial begin
    int p0, n;
    reset       = 1'b1;
    fd_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_restart(RST_PC);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset imem_req", 32'(imem_req), 32'd0);
      check("reset fd_valid", 32'(fd_valid), 32'd0);
      check("reset fd_instr", fd_instr, 32'd0);
      check("reset fd_pc", fd_pc, 32'd0);
    end

    // Straight line, latency 1
    tick;
    reset    = 1'b1;
    fd_ready = 1'b1;
    @(negedge clk);
    check("first imem_req", 32'(imem_req), 32'd1);
    check("first imem_addr", imem_addr, RST_PC);
    check("lat fd_valid c1", 32'(fd_valid), 32'd0);
    tick;
    @(negedge clk);
    check("lat fd_valid c2", 32'(fd_valid), 32'd0);
    tick;
    @(negedge clk);
    check("lat fd_valid c3", 32'(fd_valid), 32'd1);
    check("lat fd_pc c3", fd_pc, RST_PC);
    repeat (6) tick;

    // Decode stalled: buffer fills, fetch stops
    fd_ready = 1'b0;
    do_reset;
    repeat (4) tick;
    @(negedge clk);
    check("stall imem_req", 32'(imem_req), 32'd0);
    check("stall fd_valid", 32'(fd_valid), 32'd1);
    check("stall fd_pc", fd_pc, RST_PC);
    tick;
    fd_ready = 1'b1;
    repeat (10) tick;

    // Redirect with two fetches in flight, latency 2
    lat_min = 2;
    lat_max = 2;
    do_reset;
    tick;
    tick;
    do_redirect(32'h0000_0100);
    tick;
    redirect = 1'b0;
    @(negedge clk);
    check("redir imem_req", 32'(imem_req), 32'd1);
    check("redir imem_addr", imem_addr, 32'h0000_0100);
    repeat (12) tick;

    // Unaligned target
    lat_min = 1;
    lat_max = 1;
    repeat (6) tick;
    do_redirect(32'h0000_0203);
    tick;
    redirect = 1'b0;
    @(negedge clk);
    check("align imem_req", 32'(imem_req), 32'd1);
    check("align imem_addr", imem_addr, 32'h0000_0200);
    repeat (6) tick;

    // Back-to-back redirects: last wins
    do_redirect(32'h0000_0040);
    tick;
    do_redirect(32'h0000_0080);
    tick;
    redirect = 1'b0;
    @(negedge clk);
    check("b2b imem_addr", imem_addr, 32'h0000_0080);
    repeat (10) tick;

    // Address wrap
    do_redirect(32'hFFFF_FFF8);
    tick;
    redirect = 1'b0;
    repeat (14) tick;

    // Reset with one buffered and one in flight
    fd_ready = 1'b0;
    do_reset;
    tick;
    tick;
    do_reset;
    @(negedge clk);
    check("post-rst fd_valid", 32'(fd_valid), 32'd0);
    check("post-rst imem_req", 32'(imem_req), 32'd1);
    check("post-rst imem_addr", imem_addr, RST_PC);
    tick;
    fd_ready = 1'b1;
    repeat (8) tick;

    // Random traffic
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      tick;
      fd_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(799, 0) == 0) do_reset;
      else if ($urandom_range(15, 0) == 0) do_redirect($urandom);
      else redirect = 1'b0;
    end

    // Drain: delivery must keep making progress
    tick;
    redirect = 1'b0;
    fd_ready = 1'b1;
    p0 = pops;
    n  = 0;
    while (pops < p0 + 10 && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (pops < p0 + 10) begin
      errors++;
      $display("FAIL drain: delivered %0d required 10 within 200 cycles", pops - p0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
